dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-master arbiter sharing the single data memory port (async read, write on clk edge) between the CPU load/store path (master 0) and a DMA/display-scan engine (master 1).
- Round-robin grant with burst ownership; the grant is held until the burst's beat counter expires.
- Sits between the masters and the data memory; drives its Address/Write_data/MemRead/MemWrite.

Parameters:
- ADDR_W, 32, address width (byte address; memory decodes word index).
- DATA_W, 32, data width.
- LEN_W, 4, burst-length field width; a burst is m*_len+1 beats, max 16.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held high for the whole burst
- m0_we  in  1  master 0: 1 = write beat, 0 = read beat
- m0_len  in  LEN_W  master 0 beats-1, sampled at grant
- m0_addr  in  ADDR_W  master 0 beat address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  master 0 beat accepted this cycle
- m0_rdata  out  DATA_W  master 0 read data, valid when m0_ack & ~m0_we
- m1_req, m1_we, m1_len, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory Read_data
- busy  out  1  a burst is in progress
- owner  out  1  index of the current or last granted master

Behaviour:
- State machine: IDLE, BUSY. Registers: state, owner, beat counter cnt[LEN_W-1:0], round-robin pointer rr (the master favoured next).
- Reset (reset=0, async): state=IDLE, owner=0, cnt=0, rr=0. All acks, mem_read and mem_write are 0 immediately; mem_addr=0, mem_wdata=0, busy=0.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both request: grant master rr.
  - On grant: owner<=winner, cnt<=winner_len, state<=BUSY, rr<=~winner. Grant latency is 1 cycle, so the first ack comes in the cycle after the request is seen.
- BUSY, combinational outputs (all gated by owner_req):
  - mem_addr/mem_wdata = owner's addr/wdata.
  - mem_write = owner_req & owner_we.
  - mem_read = owner_req & ~owner_we.
  - owner_ack = owner_req. Non-owner ack is always 0.
  - owner_rdata = mem_rdata. Non-owner rdata = 0.
  - busy=1.
- A beat completes at the clk edge while ack=1. The master must present the next beat's addr/we/wdata after that edge. Per-beat we may change within a burst.
- Beat with cnt>0: cnt<=cnt-1.
- Last beat (cnt==0 & ack): re-arbitrate at the same edge with no bubble. If any master requests, grant it per the IDLE rules and reload cnt. A master still holding req starts a new burst only if it wins. Otherwise go to IDLE.
  - Master that keeps req high after its last beat: re-arbitrated like a new request, so with both requesting, ownership alternates.
- Abort: owner drops req in BUSY → no beat that cycle (ack=0, no memory access); state<=IDLE next edge; cnt discarded.
- Non-owner requests during BUSY are ignored until the last beat or an abort.
- IDLE outputs: mem_read=0, mem_write=0, mem_addr/mem_wdata hold 0, acks 0, rdata 0.
- Counter width: exactly LEN_W with no wrap. It is loaded only at grant and decremented only while cnt>0.
- Addresses are passed through unmodified (no auto-increment).
- Word alignment is the masters' responsibility.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding constants ST_IDLE=0, ST_BUSY=1.
  - Master index constants M_CPU=0, M_DMA=1.
  - Default LEN_W.
- Sub-module rr_pick: inputs req[1:0] and rr; outputs gnt_valid and gnt_idx. It is combinational and is instantiated once, used for both the IDLE and last-beat grant decisions.
- The main block holds the registers and the output muxes.

Test Plan:
- Read: after reset, m0 read, len=0, addr=0x40, memory word 16 holds 0xDEADBEEF → m0_ack one cycle later for 1 cycle, m0_rdata=0xDEADBEEF, mem_read=1, then IDLE with busy=0.
- Contention: both request with len=0, holding req → grants alternate m0,m1,m0,m1 on consecutive cycles with no bubble; owner toggles each cycle.
- Burst blocking: m1 write burst len=3 to 0x80..0x8C with data 1..4; m0 requests at beat 2 → m0_ack=0 for all 4 beats; m0 granted on the edge after m1's 4th beat; memory words 32..35 = 1..4.
- Abort: m0 len=7 drops req after 3 beats → exactly 3 memory writes, mem_write=0 in the drop cycle, state IDLE next edge, m1 granted afterwards.
- Reset mid-burst: assert reset (low) asynchronously between edges during an m1 write burst → mem_write and m1_ack fall without waiting for clk, busy=0, owner=0; after release, m0/m1 contention grants m0 first (rr=0).
- Len max: m0 len=15 → exactly 16 acks, then IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and types for the data-memory arbiter
package dmem_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic M_CPU     = 1'b0;
   localparam logic M_DMA     = 1'b1;
   localparam int   DEF_LEN_W = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-way round-robin winner selection (combinational)
module rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_rr,
   output logic       o_gnt_valid,
   output logic       o_gnt_idx
);

   assign o_gnt_valid = |i_req;
   // Only a tie consults the pointer; a lone requester always wins.
   assign o_gnt_idx   = (&i_req) ? i_rr : (i_req[1] ? M_DMA : M_CPU);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master burst arbiter for the shared data-memory port
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [LEN_W-1:0]  m0_len,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [LEN_W-1:0]  m1_len,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   state_t            r_state, w_state_nxt;
   logic              r_owner, w_owner_nxt;
   logic              r_rr, w_rr_nxt;
   logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;

   logic              w_own_req, w_own_we, w_beat;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_wdata;
   logic              w_gnt_valid, w_gnt_idx;
   logic [LEN_W-1:0]  w_win_len;

   assign w_own_req   = (r_owner == M_DMA) ? m1_req   : m0_req;
   assign w_own_we    = (r_owner == M_DMA) ? m1_we    : m0_we;
   assign w_own_addr  = (r_owner == M_DMA) ? m1_addr  : m0_addr;
   assign w_own_wdata = (r_owner == M_DMA) ? m1_wdata : m0_wdata;
   assign w_beat      = (r_state == ST_BUSY) & w_own_req;
   assign w_win_len   = (w_gnt_idx == M_DMA) ? m1_len : m0_len;

   rr_pick u_pick (
      .i_req       ({m1_req, m0_req}),
      .i_rr        (r_rr),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_owner <= M_CPU;
         r_cnt   <= '0;
         r_rr    <= M_CPU;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

   // The last beat falls through to the grant branch, so back-to-back bursts have no bubble.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_rr_nxt    = r_rr;
      if (r_state == ST_BUSY && !w_own_req) begin
         w_state_nxt = ST_IDLE;
      end else if (r_state == ST_BUSY && r_cnt != '0) begin
         w_cnt_nxt = r_cnt - 1'b1;
      end else if (w_gnt_valid) begin
         w_state_nxt = ST_BUSY;
         w_owner_nxt = w_gnt_idx;
         w_cnt_nxt   = w_win_len;
         w_rr_nxt    = ~w_gnt_idx;
      end else begin
         w_state_nxt = ST_IDLE;
      end
   end

   assign mem_addr  = w_beat ? w_own_addr  : '0;
   assign mem_wdata = w_beat ? w_own_wdata : '0;
   assign mem_write = w_beat & w_own_we;
   assign mem_read  = w_beat & ~w_own_we;
   assign m0_ack    = w_beat & (r_owner == M_CPU);
   assign m1_ack    = w_beat & (r_owner == M_DMA);
   assign m0_rdata  = m0_ack ? mem_rdata : '0;
   assign m1_rdata  = m1_ack ? mem_rdata : '0;
   assign busy      = (r_state == ST_BUSY);
   assign owner     = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_len, m1_len;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy, owner;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_len(m0_len), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_len(m1_len), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   // Memory: async read, write on clock edge.
   logic [31:0] bmem [0:63];
   assign mem_rdata = bmem[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) bmem[mem_addr[7:2]] <= mem_wdata;

   int wr_cnt = 0, ack0_cnt = 0;
   always @(posedge clk) begin
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (m0_ack) ack0_cnt <= ack0_cnt + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: who owns the port and how many beats remain in the burst.
   bit md_busy, md_own, md_fav;
   int md_left;
   int md_pick;

   function automatic int pick(bit r0, bit r1, bit fav);
      if (r0 && r1) return int'(fav);
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   logic md_oreq;
   assign md_pick = pick(m0_req, m1_req, md_fav);
   assign md_oreq = md_own ? m1_req : m0_req;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_busy <= 1'b0; md_own <= 1'b0; md_left <= 0; md_fav <= 1'b0;
      end else if (md_busy && md_oreq && md_left > 1) begin
         md_left <= md_left - 1;
      end else if (md_busy && !md_oreq) begin
         md_busy <= 1'b0;
      end else if (md_pick < 0) begin
         md_busy <= 1'b0;
      end else begin
         md_busy <= 1'b1;
         md_own  <= md_pick[0];
         md_left <= (md_pick == 1 ? int'(m1_len) : int'(m0_len)) + 1;
         md_fav  <= ~md_pick[0];
      end
   end

   logic        e_act, e_we;
   logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
   assign e_act   = md_busy && md_oreq;
   assign e_we    = md_own ? m1_we : m0_we;
   assign e_addr  = e_act ? (md_own ? m1_addr : m0_addr) : 32'h0;
   assign e_wdata = e_act ? (md_own ? m1_wdata : m0_wdata) : 32'h0;
   assign e_rd0   = (e_act && !md_own) ? bmem[e_addr[7:2]] : 32'h0;
   assign e_rd1   = (e_act && md_own) ? bmem[e_addr[7:2]] : 32'h0;

   always @(negedge clk) begin
      chk("acks", 64'({m1_ack, m0_ack}), 64'({e_act && md_own, e_act && !md_own}));
      chk("rd_wr", 64'({mem_read, mem_write}), 64'({e_act && !e_we, e_act && e_we}));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      chk("m0_rdata", 64'(m0_rdata), 64'(e_rd0));
      chk("m1_rdata", 64'(m1_rdata), 64'(e_rd1));
      chk("busy_owner", 64'({busy, owner}), 64'({md_busy, md_own}));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      m0_req = 0; m1_req = 0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic wait_ack(input bit m);
      int k = 0;
      @(negedge clk);
      while (!(m ? m1_ack : m0_ack) && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (k >= 40) begin
         n_total++;
         n_bad++;
         $display("FAIL ack_timeout: master %0d got no ack within 40 cycles", m);
      end
   endtask

   int base;

   initial begin
      for (int i = 0; i < 64; i++) bmem[i] = 32'h0;
      bmem[16] = 32'hDEADBEEF;
      reset = 1'b0;
      m0_req = 0; m0_we = 0; m0_len = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_len = 0; m1_addr = 0; m1_wdata = 0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_owner", 64'(owner), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      tick(1);
      reset = 1'b1;
      tick(1);

      // Single read, one-cycle grant latency
      m0_req = 1; m0_we = 0; m0_len = 0; m0_addr = 32'h40;
      @(negedge clk);
      chk("rd_latency", 64'(m0_ack), 64'(0));
      @(negedge clk);
      chk("rd_ack", 64'(m0_ack), 64'(1));
      chk("rd_data", 64'(m0_rdata), 64'(32'hDEADBEEF));
      chk("rd_memread", 64'(mem_read), 64'(1));
      tick(1);
      m0_req = 0;
      repeat (2) @(negedge clk);
      chk("rd_idle", 64'(busy), 64'(0));

      // Contention: ownership alternates every cycle
      tick(1);
      do_reset();
      m0_req = 1; m0_we = 0; m0_len = 0; m0_addr = 32'h40;
      m1_req = 1; m1_we = 0; m1_len = 0; m1_addr = 32'h80;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("alt_owner", 64'(owner), 64'(i % 2));
         chk("alt_ack", 64'({m1_ack, m0_ack}), (i % 2) ? 64'd2 : 64'd1);
      end
      tick(1);
      m0_req = 0; m1_req = 0;
      tick(3);

      // m1 write burst blocks m0 until its fourth beat
      do_reset();
      base = ack0_cnt;
      m1_req = 1; m1_we = 1; m1_len = 3;
      for (int k = 0; k < 4; k++) begin
         m1_addr = 32'h80 + 32'(4 * k);
         m1_wdata = 32'(k + 1);
         if (k == 1) begin
            m0_req = 1; m0_we = 0; m0_len = 0; m0_addr = 32'h80;
         end
         wait_ack(1'b1);
         tick(1);
      end
      m1_req = 0;
      chk("blk_m0_acks", 64'(ack0_cnt - base), 64'(0));
      @(negedge clk);
      chk("blk_owner", 64'(owner), 64'(0));
      chk("blk_m0_ack", 64'(m0_ack), 64'(1));
      chk("blk_m0_rdata", 64'(m0_rdata), 64'(1));
      for (int k = 0; k < 4; k++) chk("blk_mem", 64'(bmem[32 + k]), 64'(k + 1));
      tick(1);
      m0_req = 0;
      tick(3);

      // Abort after 3 of 8 beats, m1 waiting
      do_reset();
      base = wr_cnt;
      m0_req = 1; m0_we = 1; m0_len = 7;
      m1_req = 1; m1_we = 0; m1_len = 0; m1_addr = 32'hC0;
      for (int k = 0; k < 3; k++) begin
         m0_addr = 32'hC0 + 32'(4 * k);
         m0_wdata = 32'hA0 + 32'(k);
         wait_ack(1'b0);
         tick(1);
      end
      m0_req = 0;
      @(negedge clk);
      chk("abt_nowrite", 64'(mem_write), 64'(0));
      chk("abt_noack", 64'(m0_ack), 64'(0));
      chk("abt_busy", 64'(busy), 64'(1));
      @(negedge clk);
      chk("abt_idle", 64'(busy), 64'(0));
      @(negedge clk);
      chk("abt_m1_ack", 64'(m1_ack), 64'(1));
      chk("abt_m1_rdata", 64'(m1_rdata), 64'(32'hA0));
      chk("abt_writes", 64'(wr_cnt - base), 64'(3));
      tick(1);
      m1_req = 0;
      tick(3);

      // Asynchronous reset in the middle of an m1 write burst
      do_reset();
      m1_req = 1; m1_we = 1; m1_len = 3; m1_addr = 32'h20; m1_wdata = 32'h55;
      wait_ack(1'b1); tick(1);
      wait_ack(1'b1); tick(1);
      chk("mid_pre_write", 64'(mem_write), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_write", 64'(mem_write), 64'(0));
      chk("mid_rst_ack", 64'(m1_ack), 64'(0));
      chk("mid_rst_busy_owner", 64'({busy, owner}), 64'(0));
      m1_req = 0;
      tick(1);
      reset = 1'b1;
      m0_req = 1; m0_we = 0; m0_len = 0; m0_addr = 32'h40;
      m1_req = 1; m1_we = 0; m1_len = 0; m1_addr = 32'h80;
      @(negedge clk);
      @(negedge clk);
      chk("mid_first_owner", 64'(owner), 64'(0));
      chk("mid_first_ack", 64'(m0_ack), 64'(1));
      tick(1);
      m0_req = 0; m1_req = 0;
      tick(3);

      // Maximum burst length: 16 beats
      do_reset();
      base = ack0_cnt;
      m0_req = 1; m0_we = 0; m0_len = 4'hF; m0_addr = 32'h40;
      for (int k = 0; k < 16; k++) begin
         wait_ack(1'b0);
         tick(1);
      end
      m0_req = 0;
      tick(3);
      chk("max_acks", 64'(ack0_cnt - base), 64'(16));
      @(negedge clk);
      chk("max_idle", 64'(busy), 64'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
